// File: rtl/intra_chroma_pkg.sv
// intra_chroma_pkg: shared mode/state encodings and defaults for chroma 8x8 intra prediction
package intra_chroma_pkg;
  localparam int PIXW_DEF = 8;
  localparam int SADW_DEF = 14;
  localparam int DC_DEFAULT = 128;
  typedef enum logic [1:0] {MODE_DC = 2'd0, MODE_H = 2'd1, MODE_V = 2'd2} mode_e;
  typedef enum logic [2:0] {IDLE, LOAD, ACCUM, DECIDE, DONE} state_e;
endpackage

// File: rtl/chroma_row_sad.sv
// chroma_row_sad: sum of absolute differences across one 8-pixel row
module chroma_row_sad #(
  parameter int PIXW = 8
) (
  input  logic [PIXW-1:0] cur_i [8],
  input  logic [PIXW-1:0] pred_i [8],
  output logic [PIXW+2:0] sad_o
);
  // eight PIXW-bit differences need three extra bits of headroom
  always_comb begin
    sad_o = '0;
    for (int c = 0; c < 8; c++)
      sad_o = sad_o + (PIXW+3)'(cur_i[c] > pred_i[c] ? cur_i[c] - pred_i[c] : pred_i[c] - cur_i[c]);
  end
endmodule

// File: rtl/intra_pred_chroma8x8.sv
// intra_pred_chroma8x8: chroma 8x8 DC/H/V prediction with row-serial SAD mode decision
// Define CHROMA_RESIDUAL_EN to add the registered out_resid (mb - out_pred) output.
module intra_pred_chroma8x8
  import intra_chroma_pkg::*;
#(
  parameter int PIXW = PIXW_DEF,
  parameter int SADW = SADW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PIXW-1:0] mb [64],
  input  logic [PIXW-1:0] toppixels [8],
  input  logic [PIXW-1:0] leftpixels [8],
  input  logic            top_avail,
  input  logic            left_avail,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      out_mode,
  output logic [SADW-1:0] out_sad,
  output logic [PIXW-1:0] out_pred [64]
`ifdef CHROMA_RESIDUAL_EN
  ,
  output logic signed [PIXW:0] out_resid [64]
`endif
);
  localparam int SUMW = PIXW + 3;
  state_e          state_q, state_d;
  mode_e           mode_q, win;
  logic            rdy_q, ta_q, la_q;
  logic [2:0]      row_q;
  logic [PIXW-1:0] mb_q [64];
  logic [PIXW-1:0] top_q [8];
  logic [PIXW-1:0] left_q [8];
  logic [PIXW-1:0] dc_q [4];
  logic [PIXW-1:0] dc_d [4];
  logic [SADW-1:0] sad_q [3];
  logic [SUMW-1:0] row_sad [3];
  logic [PIXW-1:0] cur_row [8];
  logic [PIXW-1:0] dc_row [8];
  logic [PIXW-1:0] h_row [8];
  logic [PIXW-1:0] pred_q [64];
  logic [PIXW-1:0] pred_d [64];
  logic [SADW-1:0] osad_q, best;
  logic [SUMW-1:0] st_lo, st_hi, sl_lo, sl_hi;

  function automatic logic [PIXW-1:0] dc_of(input logic [SUMW-1:0] st, input logic [SUMW-1:0] sl,
                                            input logic ut, input logic ul);
    logic [SUMW-1:0] v;
    v = ut && ul ? (st + sl + SUMW'(4)) >> 3 : ut ? (st + SUMW'(2)) >> 2 :
        ul ? (sl + SUMW'(2)) >> 2 : SUMW'(DC_DEFAULT);
    return v[PIXW-1:0];
  endfunction

  // quadrant DC values; off-diagonal quadrants prefer their own-side neighbour, then the other
  always_comb begin
    st_lo = '0;
    st_hi = '0;
    sl_lo = '0;
    sl_hi = '0;
    for (int i = 0; i < 4; i++) begin
      st_lo = st_lo + SUMW'(top_q[i]);
      st_hi = st_hi + SUMW'(top_q[i+4]);
      sl_lo = sl_lo + SUMW'(left_q[i]);
      sl_hi = sl_hi + SUMW'(left_q[i+4]);
    end
    dc_d[0] = dc_of(st_lo, sl_lo, ta_q, la_q);
    dc_d[1] = dc_of(st_hi, sl_lo, ta_q, la_q && !ta_q);
    dc_d[2] = dc_of(st_lo, sl_hi, ta_q && !la_q, la_q);
    dc_d[3] = dc_of(st_hi, sl_hi, ta_q, la_q);
  end

  // current row and its DC/H predictions for the row being accumulated
  always_comb begin
    for (int c = 0; c < 8; c++) begin
      cur_row[c] = mb_q[{row_q, 3'(c)}];
      dc_row[c] = dc_q[{row_q[2], c >= 4}];
      h_row[c] = left_q[row_q];
    end
  end

  chroma_row_sad #(.PIXW(PIXW)) u_sad_dc (.cur_i(cur_row), .pred_i(dc_row), .sad_o(row_sad[0]));
  chroma_row_sad #(.PIXW(PIXW)) u_sad_h  (.cur_i(cur_row), .pred_i(h_row),  .sad_o(row_sad[1]));
  chroma_row_sad #(.PIXW(PIXW)) u_sad_v  (.cur_i(cur_row), .pred_i(top_q),  .sad_o(row_sad[2]));

  // minimum SAD over eligible modes; strict compares give ties to the lower mode
  always_comb begin
    win = MODE_DC;
    best = sad_q[0];
    if (la_q && sad_q[1] < best) begin
      win = MODE_H;
      best = sad_q[1];
    end
    if (ta_q && sad_q[2] < best) begin
      win = MODE_V;
      best = sad_q[2];
    end
    for (int i = 0; i < 64; i++)
      pred_d[i] = win == MODE_H ? left_q[i[5:3]] : win == MODE_V ? top_q[i[2:0]] : dc_q[{i[5], i[2]}];
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = in_valid && in_ready ? LOAD : IDLE;
      LOAD:    state_d = ACCUM;
      ACCUM:   state_d = row_q == 3'd7 ? DECIDE : ACCUM;
      DECIDE:  state_d = DONE;
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;

  // datapath: latch on accept, DC setup, row accumulation, result capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_q <= 1'b0;
      ta_q <= 1'b0;
      la_q <= 1'b0;
      row_q <= '0;
      mode_q <= MODE_DC;
      osad_q <= '0;
      for (int i = 0; i < 64; i++) begin
        mb_q[i] <= '0;
        pred_q[i] <= '0;
      end
      for (int i = 0; i < 8; i++) begin
        top_q[i] <= '0;
        left_q[i] <= '0;
      end
      for (int i = 0; i < 4; i++) dc_q[i] <= '0;
      for (int i = 0; i < 3; i++) sad_q[i] <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (in_valid && in_ready) begin
        mb_q <= mb;
        top_q <= toppixels;
        left_q <= leftpixels;
        ta_q <= top_avail;
        la_q <= left_avail;
      end
      if (state_q == LOAD) begin
        dc_q <= dc_d;
        row_q <= '0;
        for (int m = 0; m < 3; m++) sad_q[m] <= '0;
      end
      if (state_q == ACCUM) begin
        row_q <= row_q + 3'd1;
        for (int m = 0; m < 3; m++) sad_q[m] <= sad_q[m] + SADW'(row_sad[m]);
      end
      if (state_q == DECIDE) begin
        mode_q <= win;
        osad_q <= best;
        pred_q <= pred_d;
      end
    end
  end

`ifdef CHROMA_RESIDUAL_EN
  logic signed [PIXW:0] resid_q [64];

  // residual captured with the prediction it was formed against
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) resid_q[i] <= '0;
    end else if (state_q == DECIDE) begin
      for (int i = 0; i < 64; i++) resid_q[i] <= $signed({1'b0, mb_q[i]}) - $signed({1'b0, pred_d[i]});
    end
  end

  assign out_resid = resid_q;
`endif

  assign in_ready = rdy_q && state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_mode = mode_q;
  assign out_sad = osad_q;
  assign out_pred = pred_q;
endmodule

// File: tb/tb_intra_pred_chroma8x8.sv
// tb_intra_pred_chroma8x8: directed and randomized self-checking bench for intra_pred_chroma8x8
module tb_intra_pred_chroma8x8;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        top_avail = 1'b0;
  logic        left_avail = 1'b0;
  logic        in_ready, out_valid;
  logic [7:0]  mb [64];
  logic [7:0]  top [8];
  logic [7:0]  left [8];
  logic [1:0]  out_mode;
  logic [13:0] out_sad;
  logic [7:0]  out_pred [64];
`ifdef CHROMA_RESIDUAL_EN
  logic signed [8:0] out_resid [64];
  int exp_resid [64];
`endif
  int n_checks = 0;
  int n_err = 0;
  int exp_mode, exp_sad;
  int exp_pred [64];

  always #5 clk = ~clk;

  intra_pred_chroma8x8 dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mb(mb), .toppixels(top), .leftpixels(left),
    .top_avail(top_avail), .left_avail(left_avail),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mode(out_mode), .out_sad(out_sad), .out_pred(out_pred)
`ifdef CHROMA_RESIDUAL_EN
    , .out_resid(out_resid)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rnd_div(input int s, input int n);
    return (s + n / 2) / n;
  endfunction

  function automatic int pred_bad();
    int b = 0;
    for (int i = 0; i < 64; i++) if (out_pred[i] !== 8'(exp_pred[i])) b++;
    return b;
  endfunction

  // reference: build all three predictions from the rules, score them, pick the winner
  task automatic model();
    int t0 = 0, t1 = 0, l0 = 0, l1 = 0;
    int q [4];
    int sad [3];
    int p [3][64];
    for (int i = 0; i < 4; i++) begin
      t0 += top[i];
      t1 += top[i+4];
      l0 += left[i];
      l1 += left[i+4];
    end
    q[0] = top_avail && left_avail ? rnd_div(t0 + l0, 8) : top_avail ? rnd_div(t0, 4) : left_avail ? rnd_div(l0, 4) : 128;
    q[1] = top_avail ? rnd_div(t1, 4) : left_avail ? rnd_div(l0, 4) : 128;
    q[2] = left_avail ? rnd_div(l1, 4) : top_avail ? rnd_div(t0, 4) : 128;
    q[3] = top_avail && left_avail ? rnd_div(t1 + l1, 8) : top_avail ? rnd_div(t1, 4) : left_avail ? rnd_div(l1, 4) : 128;
    sad = '{0, 0, 0};
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        p[0][r*8+c] = q[(r / 4) * 2 + c / 4];
        p[1][r*8+c] = left[r];
        p[2][r*8+c] = top[c];
        for (int m = 0; m < 3; m++) begin
          int d;
          d = int'(mb[r*8+c]) - p[m][r*8+c];
          sad[m] += d < 0 ? -d : d;
        end
      end
    exp_mode = 0;
    if (left_avail && sad[1] < sad[exp_mode]) exp_mode = 1;
    if (top_avail && sad[2] < sad[exp_mode]) exp_mode = 2;
    exp_sad = sad[exp_mode];
    for (int i = 0; i < 64; i++) begin
      exp_pred[i] = p[exp_mode][i];
`ifdef CHROMA_RESIDUAL_EN
      exp_resid[i] = int'(mb[i]) - p[exp_mode][i];
`endif
    end
  endtask

  task automatic fill(input int mv, input int tv, input int lv, input logic ta, input logic la);
    for (int i = 0; i < 64; i++) mb[i] = 8'(mv);
    for (int i = 0; i < 8; i++) begin
      top[i] = 8'(tv);
      left[i] = 8'(lv);
    end
    top_avail = ta;
    left_avail = la;
  endtask

  task automatic scramble();
    for (int i = 0; i < 64; i++) mb[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      top[i] = 8'($urandom);
      left[i] = 8'($urandom);
    end
    top_avail = 1'($urandom);
    left_avail = 1'($urandom);
  endtask

  task automatic accept(input string tag);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic run_block(input string tag, input int hold);
    int n = 0;
    int bad = 0;
    model();
    accept(tag);
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, ".latency"}, n, 10);
    check({tag, ".mode"}, out_mode, exp_mode);
    check({tag, ".sad"}, out_sad, exp_sad);
    check({tag, ".pred_bad"}, pred_bad(), 0);
    check({tag, ".busy"}, in_ready, 0);
`ifdef CHROMA_RESIDUAL_EN
    for (int i = 0; i < 64; i++) if (out_resid[i] !== 9'(exp_resid[i])) bad++;
    check({tag, ".resid_bad"}, bad, 0);
    bad = 0;
`endif
    if (hold > 0) begin
      in_valid = 1'b1;
      repeat (hold) begin
        @(posedge clk);
        #1;
        if (!out_valid || in_ready || out_mode !== 2'(exp_mode) || out_sad !== 14'(exp_sad) || pred_bad() != 0) bad++;
      end
      in_valid = 1'b0;
      check({tag, ".stall"}, bad, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".release_valid"}, out_valid, 0);
    check({tag, ".release_ready"}, in_ready, 1);
  endtask

  initial begin
    int n;
    fill(0, 0, 0, 1'b0, 1'b0);
    #1;
    check("rst.in_ready", in_ready, 0);
    check("rst.out_valid", out_valid, 0);
    check("rst.out_mode", out_mode, 0);
    check("rst.out_sad", out_sad, 0);
    for (int i = 0; i < 64; i++) exp_pred[i] = 0;
    check("rst.pred_bad", pred_bad(), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst.ready_before_edge", in_ready, 0);
    @(posedge clk);
    #1;
    check("rst.ready_after_edge", in_ready, 1);

    fill(100, 100, 50, 1'b1, 1'b1);
    run_block("vert", 0);
    check("vert.mode_lit", out_mode, 2);
    check("vert.sad_lit", out_sad, 0);
    check("vert.pred0_lit", out_pred[0], 100);

    fill(128, 7, 9, 1'b0, 1'b0);
    run_block("none128", 0);
    check("none128.mode_lit", out_mode, 0);
    check("none128.pred_lit", out_pred[63], 128);
    fill(0, 7, 9, 1'b0, 1'b0);
    run_block("none0", 0);
    check("none0.sad_lit", out_sad, 8192);

    fill(0, 200, 0, 1'b0, 1'b1);
    for (int r = 0; r < 8; r++) begin
      left[r] = 8'(r * 10);
      for (int c = 0; c < 8; c++) mb[r*8+c] = 8'(r * 10);
    end
    run_block("horiz", 0);
    check("horiz.mode_lit", out_mode, 1);
    check("horiz.sad_lit", out_sad, 0);
    fill(0, 200, 0, 1'b0, 1'b0);
    for (int r = 0; r < 8; r++) begin
      left[r] = 8'(r * 10);
      for (int c = 0; c < 8; c++) mb[r*8+c] = 8'(r * 10);
    end
    run_block("horiz_na", 0);
    check("horiz_na.mode_lit", out_mode, 0);
    check("horiz_na.sad_lit", out_sad, 5952);

    fill(60, 60, 60, 1'b1, 1'b1);
    run_block("tie", 0);
    check("tie.mode_lit", out_mode, 0);

    fill(80, 80, 80, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      top[i] = 8'd40;
      left[i] = 8'd40;
    end
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) mb[r*8+c] = 8'd40;
    run_block("dcquad", 0);
    check("dcquad.mode_lit", out_mode, 0);
    check("dcquad.q00", out_pred[0], 40);
    check("dcquad.q01", out_pred[7], 80);
    check("dcquad.q10", out_pred[56], 80);
    check("dcquad.q11", out_pred[63], 80);

    fill(33, 90, 10, 1'b1, 1'b1);
    for (int i = 0; i < 64; i++) mb[i] = 8'($urandom_range(60, 120));
    run_block("stall", 20);
    n = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid) n++;
    end
    check("stall.no_second_accept", n, 0);

    fill(0, 0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 64; i++) mb[i] = 8'($urandom);
    accept("abort");
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort.out_valid", out_valid, 0);
    check("abort.in_ready", in_ready, 0);
    check("abort.out_mode", out_mode, 0);
    check("abort.out_sad", out_sad, 0);
    for (int i = 0; i < 64; i++) exp_pred[i] = 0;
    check("abort.pred_bad", pred_bad(), 0);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) n++;
    end
    check("abort.no_result", n, 0);
    fill(70, 70, 20, 1'b1, 1'b1);
    run_block("after_abort", 0);

    for (int k = 0; k < 24; k++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      for (int i = 0; i < 8; i++) begin
        top[i] = 8'($urandom);
        left[i] = 8'($urandom);
      end
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          int v;
          v = kind == 0 ? int'($urandom_range(0, 255)) :
              kind == 1 ? int'(left[r]) + int'($urandom_range(0, 6)) - 3 :
                          int'(top[c]) + int'($urandom_range(0, 6)) - 3;
          mb[r*8+c] = 8'(v < 0 ? 0 : v > 255 ? 255 : v);
        end
      top_avail = 1'($urandom);
      left_avail = 1'($urandom);
      run_block($sformatf("rand%0d", k), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/intra_pred_chroma8x8.md
Name: intra_pred_chroma8x8

Overview:
Chroma 8x8 intra prediction and mode-decision stage, directly downstream of the chroma 8x8 block extractor. Inputs per block:
- 64 current pixels
- 8 top and 8 left neighbours
- neighbour-availability flags

It evaluates DC, horizontal and vertical modes by row-serial SAD. It returns the winning mode, its SAD and the 8x8 predicted block to the residual/transform stage over a valid/ready handshake.

Parameters:
PIXW, 8, pixel bit width.
SADW, 14, SAD accumulator width; 64*255 = 16320 fits in 14 bits.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  block and neighbours valid.
in_ready  out  1  block can accept; high only in IDLE.
mb  in  PIXW x64  current pixels, index (row<<3)+col.
toppixels  in  PIXW x8  row above, index = col.
leftpixels  in  PIXW x8  column to the left, index = row.
top_avail  in  1  top neighbours are real data.
left_avail  in  1  left neighbours are real data.
out_valid  out  1  result valid; held until accepted.
out_ready  in  1  downstream accepts the result.
out_mode  out  2  0=DC, 1=horizontal, 2=vertical; 3 never produced.
out_sad  out  SADW  SAD of the chosen mode.
out_pred  out  PIXW x64  predicted block for the chosen mode.

Behaviour:
- Reset (async, reset=0):
  - State goes to IDLE; all accumulators and registers clear.
  - Outputs: in_ready=0, out_valid=0, out_mode=0, out_sad=0, out_pred all 0.
  - in_ready rises on the first clock after reset deasserts.
  - Reset asserted mid-block aborts the block; no partial result is ever emitted.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch mb, toppixels, leftpixels and both avail flags, then go to LOAD. Input is sampled only on this handshake.
  - LOAD (1 cycle): compute the four DC quadrant values and clear the three SAD accumulators.
  - ACCUM (8 cycles, row counter 0..7): for row r, add sum over col of |mb - pred_m| to each mode-m accumulator. Counter wraps 7 -> DECIDE.
  - DECIDE (1 cycle): select mode, register out_mode, out_sad and out_pred.
  - DONE: out_valid=1, outputs stable. On out_ready, go to IDLE with out_valid=0 on the next edge.
- Latency: out_valid rises on the 10th rising edge after the accepting edge. With out_ready held high, throughput is one block per 12 cycles.
- Prediction rules:
  - H: pred[r][c] = left[r].
  - V: pred[r][c] = top[c].
  - DC, per 4x4 quadrant. St = sum of the quadrant's 4 top pixels; Sl = sum of its 4 left pixels.
  - Quadrants (0,0) and (1,1):
    - both available: (St+Sl+4)>>3
    - top only: (St+2)>>2
    - left only: (Sl+2)>>2
    - neither: 128
  - Quadrant (x4..7, y0..3): top if available, else left, else 128.
  - Quadrant (x0..3, y4..7): left if available, else top, else 128.
- Mode eligibility:
  - DC is always eligible.
  - H requires left_avail; V requires top_avail.
  - Ineligible modes are never chosen.
- Decision:
  - Minimum SAD among eligible modes.
  - Ties go to the lower mode number (DC < H < V).
- Arithmetic:
  - Absolute differences are PIXW bits.
  - Per-row sum is 11 bits; accumulators are SADW bits and unsigned, with no saturation needed.
- in_valid while busy is ignored (in_ready=0). Upstream holds its data.

Optional Feature:
Macro CHROMA_RESIDUAL_EN.
- Defined: adds output port out_resid, signed PIXW+1 bits x64, equal to mb - out_pred. It is registered in DECIDE alongside out_pred, resets to 0 and is valid whenever out_valid=1.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package intra_chroma_pkg holds:
  - mode encodings: MODE_DC=0, MODE_H=1, MODE_V=2
  - FSM state enum: IDLE, LOAD, ACCUM, DECIDE, DONE
  - constant DC_DEFAULT=128
  - PIXW/SADW defaults
- One sub-module, chroma_row_sad: given one row of current pixels and one row of predicted pixels, it returns the 11-bit sum of absolute differences. It is instantiated three times (once per mode).

Test Plan:
- Both neighbours available; mb all 100, top all 100, left all 50 -> mode=2 (V), sad=0, out_pred all 100, out_valid on the 10th edge after acceptance.
- Neither neighbour available; mb all 128 -> mode=0, sad=0, pred all 128. Also with mb all 0 -> sad=8192, mode=0.
- top_avail=0, left_avail=1, left[r]=r*10, mb[r][c]=r*10 -> mode=1, sad=0. Repeat with left_avail=0 -> mode=0 even though H would score 0.
- Tie: top all 60, left all 60, mb all 60 -> DC, H and V all score 0 -> mode=0. The same stimulus with the DC quadrant rule checked: top 0..3=40, top 4..7=80, left 0..3=40, left 4..7=80 gives quadrant DC values 40, 80, 80, 80.
- Backpressure: hold out_ready=0 for 20 cycles -> out_valid and all outputs stay stable, in_ready=0, and a second in_valid is not accepted. Release -> one cycle later, IDLE with in_ready=1.
- Reset pulse during ACCUM row 4 -> out_valid never rises for that block, all outputs read 0, and the next block after reset completes correctly.
